ps2_led_cmd: RTL and testbench
==============================

PS2_LED_CMD -- requirements
Module: ps2_led_cmd

Interface
REQ-001 SHALL have parameter CLK, default 50, meaning clock frequency in MHz.
REQ-002 SHALL have parameter TIMEOUT_MS, default 20, meaning the ACK wait limit in milliseconds.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning the resends allowed per byte.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are listed below.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- led_req  in  1  request to program the keyboard LEDs.
- led_val  in  3  LED value: [0] scroll, [1] num, [2] caps.
- led_busy  out  1  a command sequence is in progress.
- led_done  out  1  one-cycle pulse: sequence acknowledged.
- led_err  out  1  one-cycle pulse: sequence aborted.
- send_req  out  1  byte request to the PS2 transmitter.
- send_data  out  8  byte to transmit.
- send_idle  in  1  transmitter idle (high = ready or finished).
- rx_valid  in  1  one-cycle pulse: byte received from the device.
- rx_data  in  8  received byte; valid while rx_valid is high.

Function
REQ-005 SHALL implement these states: IDLE, SEND, WAIT_TX, WAIT_ACK, DONE, ERR; a 1-bit byte index selects between the command byte 0xED (index 0) and the argument byte {5'b0, led_val_q} (index 1).
REQ-006 In IDLE, when led_req=1 the block SHALL latch led_val into led_val_q, clear the byte index and the retry count, assert led_busy, and go to SEND.
REQ-007 led_req SHALL be ignored while led_busy=1; led_val changes after capture SHALL NOT affect the argument byte.
REQ-008 In SEND the block SHALL drive send_req=1 and send_data=selected byte, and hold them until send_idle is sampled 0 (byte accepted); it SHALL then deassert send_req on the next cycle and go to WAIT_TX.
REQ-009 In WAIT_TX, when send_idle returns to 1 the block SHALL load the timeout counter and go to WAIT_ACK.
REQ-010 The timeout counter SHALL load CLK*1000*TIMEOUT_MS, have width $clog2 of that value plus 1, decrement only in WAIT_ACK, and expire when it reaches 0.
REQ-011 In WAIT_ACK:
- rx_valid with rx_data=0xFA at index 0 SHALL set the index to 1, clear the retry count, and go to SEND.
- rx_valid with rx_data=0xFA at index 1 SHALL go to DONE.
- rx_valid with rx_data=0xFE SHALL follow the REQ-018 retry behaviour.
- rx_valid with any other byte SHALL be ignored.
REQ-012 If rx_valid arrives in the same cycle the timer expires, the received byte SHALL take priority.
REQ-013 Timer expiry with no valid byte SHALL go to ERR.
REQ-014 DONE SHALL pulse led_done for 1 cycle; ERR SHALL pulse led_err for 1 cycle; both states SHALL return to IDLE on the next cycle with led_busy=0.
REQ-015 rx_valid outside WAIT_ACK SHALL be ignored.
REQ-016 Outputs SHALL be registered; send_req SHALL never be asserted outside SEND.

Reset
REQ-017 On rst_n=0, asynchronously and regardless of the current state:
- state SHALL go to IDLE.
- led_busy, led_done, led_err and send_req SHALL be 0.
- send_data SHALL be 0x00.
- the counter SHALL be loaded with the timeout value.
- the retry count, byte index and led_val_q SHALL be 0.
No transmission SHALL resume after reset is released.

Configuration
REQ-018 Macro PS2_LED_CMD_RETRY_EN:
- When defined, 0xFE in WAIT_ACK SHALL increment the retry count and return to SEND with the same byte.
- When defined, an 0xFE arriving with the retry count already equal to MAX_RETRY SHALL go to ERR.
- When undefined, 0xFE SHALL go directly to ERR, and no retry counter SHALL be synthesized.

Verification
REQ-019 Benches SHALL use CLK=1 and TIMEOUT_MS=1 (1000-cycle timeout) and cover:
- Normal sequence: led_req with led_val=3'b101, model ACKs 0xFA twice -> send_data 0xED then 0x05; one led_done pulse; led_busy low afterwards.
- Timeout: no response after 0xED -> led_err pulse 1000±2 cycles after send_idle rises; no 0x05 sent.
- Resend with RETRY_EN: 0xFE after 0x05 three times, then 0xFA -> 0x05 sent 4 times, then led_done.
- Retry exhausted: 0xFE four times with RETRY_EN, or once without it -> led_err pulse and return to IDLE.
- Noise and overlap: rx_data 0xAA during WAIT_ACK is ignored, and led_req during busy is ignored -> exactly one sequence, carrying the first led_val.
- Async reset mid-operation: rst_n low during WAIT_TX -> send_req=0 and led_busy=0 immediately; no led_done or led_err after release.

Source files
------------

// File: rtl/ps2_led_cmd.sv
// PS/2 keyboard LED programming sequencer: sends 0xED then the LED byte, waits for ACKs.
// Optional resend-on-0xFE behaviour is enabled by defining PS2_LED_CMD_RETRY_EN.
module ps2_led_cmd #(
  parameter int CLK        = 50,
  parameter int TIMEOUT_MS = 20,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       led_busy,
  output logic       led_done,
  output logic       led_err,
  output logic       send_req,
  output logic [7:0] send_data,
  input  logic       send_idle,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int TMO_CYC = CLK * 1000 * TIMEOUT_MS;
  localparam int TW      = $clog2(TMO_CYC) + 1;
  localparam logic [TW-1:0] TMO_LD = TW'(TMO_CYC);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_TX  = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            idx_q, idx_d;
  logic [2:0]      val_q, val_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic [7:0]      data_q, data_d;

  logic rx_ack, rx_resend;
  assign rx_ack    = rx_valid && (rx_data == 8'hFA);
  assign rx_resend = rx_valid && (rx_data == 8'hFE);

`ifdef PS2_LED_CMD_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q, retry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
`ifdef PS2_LED_CMD_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (led_req) begin
          val_d   = led_val;
          idx_d   = 1'b0;
`ifdef PS2_LED_CMD_RETRY_EN
          retry_d = '0;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (!send_idle) state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (send_idle) begin
          cnt_d   = TMO_LD;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != '0) cnt_d = cnt_q - TW'(1);
        // A received byte wins over a timer expiring in the same cycle.
        if (rx_ack) begin
          if (!idx_q) begin
            idx_d   = 1'b1;
`ifdef PS2_LED_CMD_RETRY_EN
            retry_d = '0;
`endif
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end else if (rx_resend) begin
`ifdef PS2_LED_CMD_RETRY_EN
          if (retry_q == RW'(MAX_RETRY)) begin
            state_d = ERR;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end
`else
          state_d = ERR;
`endif
        end else if (cnt_q == '0) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
    req_d  = (state_d == SEND);
    data_d = data_q;
    if (state_d == SEND) data_d = idx_d ? {5'b0, val_d} : 8'hED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      val_q   <= 3'b000;
      cnt_q   <= TMO_LD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign led_busy  = busy_q;
  assign led_done  = done_q;
  assign led_err   = err_q;
  assign send_req  = req_q;
  assign send_data = data_q;

endmodule

// File: tb/tb_ps2_led_cmd.sv
// Directed bench for ps2_led_cmd with a small PS/2 transmitter model (5-cycle byte time).
module tb_ps2_led_cmd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       led_busy, led_done, led_err, send_req;
  logic [7:0] send_data;
  logic       send_idle = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_sent = 0;
  int tx_cnt = 0;
  int t_rise = 0;
  int n_done = 0;
  int n_err = 0;
  int t_err = 0;
  logic [7:0] sent_b [0:63];

  ps2_led_cmd #(.CLK(1), .TIMEOUT_MS(1), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .led_req(led_req), .led_val(led_val),
    .led_busy(led_busy), .led_done(led_done), .led_err(led_err),
    .send_req(send_req), .send_data(send_data), .send_idle(send_idle),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: accepts a byte when idle and requested, busy for 5 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_cnt = 0;
      send_idle = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        send_idle = 1'b1;
        t_rise = cyc;
      end
    end else if (send_req && send_idle) begin
      send_idle = 1'b0;
      tx_cnt = 5;
      if (n_sent < 64) sent_b[n_sent] = send_data;
      n_sent = n_sent + 1;
    end
  end

  always @(negedge clk) begin
    if (led_done) n_done = n_done + 1;
    if (led_err) begin
      n_err = n_err + 1;
      t_err = cyc;
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] v);
    @(negedge clk);
    led_req = 1'b1;
    led_val = v;
    @(negedge clk);
    led_req = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_sent(input int n, input string nm);
    int k;
    k = 0;
    while (!(n_sent >= n && send_idle) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL %s: bytes sent %0d, required %0d within 300 cycles", nm, n_sent, n);
    end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if ({led_busy, led_done, led_err, send_req} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {led_busy, led_done, led_err, send_req});
    end
    checks++;
    if (send_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h, required 00", send_data);
    end
    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    checks++;
    if ({led_busy, send_req} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: busy/req %b, required 00", {led_busy, send_req});
    end
  endtask

  task automatic test_normal;
    int base, d0, e0;
    base = n_sent; d0 = n_done; e0 = n_err;
    request(3'b101);
    checks++;
    if (led_busy !== 1'b1) begin
      errors++;
      $display("FAIL normal_busy: got %b, required 1", led_busy);
    end
    wait_sent(base + 1, "normal_cmd");
    checks++;
    if (sent_b[base] !== 8'hED) begin
      errors++;
      $display("FAIL normal_cmd_byte: got %h, required ED", sent_b[base]);
    end
    rx_byte(8'hFA);
    wait_sent(base + 2, "normal_arg");
    checks++;
    if (sent_b[base+1] !== 8'h05) begin
      errors++;
      $display("FAIL normal_arg_byte: got %h, required 05", sent_b[base+1]);
    end
    rx_byte(8'hFA);
    idle_cycles(4);
    checks++;
    if (n_done - d0 != 1 || n_err != e0) begin
      errors++;
      $display("FAIL normal_pulses: done %0d err %0d, required 1 0", n_done - d0, n_err - e0);
    end
    checks++;
    if (led_busy !== 1'b0 || n_sent != base + 2) begin
      errors++;
      $display("FAIL normal_end: busy %b sent %0d, required 0 %0d", led_busy, n_sent - base, 2);
    end
  endtask

  task automatic test_timeout;
    int base, d0, e0, k, dt;
    base = n_sent; d0 = n_done; e0 = n_err;
    request(3'b010);
    wait_sent(base + 1, "timeout_cmd");
    k = 0;
    while (n_err == e0 && k < 1200) begin
      @(posedge clk);
      #1;
      k++;
    end
    dt = t_err - t_rise;
    checks++;
    if (n_err - e0 != 1) begin
      errors++;
      $display("FAIL timeout_err: err pulses %0d, required 1", n_err - e0);
    end
    checks++;
    if (dt < 998 || dt > 1002) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles, required 1000+-2", dt);
    end
    idle_cycles(3);
    checks++;
    if (n_sent != base + 1 || n_done != d0 || led_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_end: sent %0d done %0d busy %b, required 1 0 0", n_sent - base, n_done - d0, led_busy);
    end
  endtask

  task automatic test_retry;
    int base, d0, e0, n05;
    base = n_sent; d0 = n_done; e0 = n_err;
    request(3'b101);
    wait_sent(base + 1, "retry_cmd");
    rx_byte(8'hFA);
`ifdef PS2_LED_CMD_RETRY_EN
    for (int i = 0; i < 3; i++) begin
      wait_sent(base + 2 + i, "retry_resend");
      rx_byte(8'hFE);
    end
    wait_sent(base + 5, "retry_last");
    rx_byte(8'hFA);
    idle_cycles(4);
    n05 = 0;
    for (int i = 1; i < 5; i++) if (sent_b[base+i] === 8'h05) n05++;
    checks++;
    if (n05 != 4 || n_sent != base + 5) begin
      errors++;
      $display("FAIL retry_count: 05 sent %0d total %0d, required 4 5", n05, n_sent - base);
    end
    checks++;
    if (n_done - d0 != 1 || n_err != e0) begin
      errors++;
      $display("FAIL retry_done: done %0d err %0d, required 1 0", n_done - d0, n_err - e0);
    end
`else
    wait_sent(base + 2, "retry_arg");
    rx_byte(8'hFE);
    idle_cycles(10);
    n05 = (sent_b[base+1] === 8'h05) ? 1 : 0;
    checks++;
    if (n05 != 1 || n_sent != base + 2) begin
      errors++;
      $display("FAIL noretry_sent: 05 sent %0d total %0d, required 1 2", n05, n_sent - base);
    end
    checks++;
    if (n_err - e0 != 1 || n_done != d0 || led_busy !== 1'b0) begin
      errors++;
      $display("FAIL noretry_err: err %0d done %0d busy %b, required 1 0 0", n_err - e0, n_done - d0, led_busy);
    end
`endif
  endtask

  task automatic test_retry_exhausted;
    int base, d0, e0, nres;
    base = n_sent; d0 = n_done; e0 = n_err;
    request(3'b001);
`ifdef PS2_LED_CMD_RETRY_EN
    nres = 4;
`else
    nres = 1;
`endif
    for (int i = 0; i < nres; i++) begin
      wait_sent(base + 1 + i, "exhaust_cmd");
      rx_byte(8'hFE);
    end
    idle_cycles(10);
    checks++;
    if (n_err - e0 != 1 || n_done != d0) begin
      errors++;
      $display("FAIL exhaust_err: err %0d done %0d, required 1 0", n_err - e0, n_done - d0);
    end
    checks++;
    if (n_sent != base + nres || led_busy !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_end: sent %0d busy %b, required %0d 0", n_sent - base, led_busy, nres);
    end
  endtask

  task automatic test_noise_overlap;
    int base, d0, e0;
    base = n_sent; d0 = n_done; e0 = n_err;
    request(3'b011);
    led_req = 1'b1;
    led_val = 3'b110;
    repeat (3) @(negedge clk);
    led_req = 1'b0;
    wait_sent(base + 1, "noise_cmd");
    rx_byte(8'hAA);
    idle_cycles(3);
    checks++;
    if (n_sent != base + 1 || led_busy !== 1'b1 || n_err != e0) begin
      errors++;
      $display("FAIL noise_ignored: sent %0d busy %b err %0d, required 1 1 0", n_sent - base, led_busy, n_err - e0);
    end
    rx_byte(8'hFA);
    wait_sent(base + 2, "noise_arg");
    checks++;
    if (sent_b[base+1] !== 8'h03) begin
      errors++;
      $display("FAIL overlap_arg: got %h, required 03", sent_b[base+1]);
    end
    rx_byte(8'hFA);
    idle_cycles(4);
    rx_byte(8'hFA);
    idle_cycles(10);
    checks++;
    if (n_done - d0 != 1 || n_sent != base + 2 || led_busy !== 1'b0) begin
      errors++;
      $display("FAIL overlap_single: done %0d sent %0d busy %b, required 1 2 0", n_done - d0, n_sent - base, led_busy);
    end
  endtask

  task automatic test_reset_mid;
    int base, d0, e0, k;
    base = n_sent; d0 = n_done; e0 = n_err;
    request(3'b111);
    k = 0;
    while (n_sent < base + 1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (led_busy !== 1'b1 || send_idle !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: busy %b idle %b, required 1 0", led_busy, send_idle);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (send_req !== 1'b0 || led_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: req %b busy %b, required 0 0", send_req, led_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(50);
    checks++;
    if (n_done != d0 || n_err != e0 || n_sent != base + 1 || led_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: done %0d err %0d sent %0d busy %b, required 0 0 1 0",
               n_done - d0, n_err - e0, n_sent - base, led_busy);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_timeout;
    test_retry;
    test_retry_exhausted;
    test_noise_overlap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
